vga_mem_arbiter: RTL and testbench

Single-port memory arbiter that shares one synchronous-read RAM port between two requesters: the host (the native read/write side of the AXI-Lite slave) and the display fetch engine that streams pixel/register words to the VGA timing pipeline. The display requester has priority. A starvation guard bounds host latency. Host requests are buffered in one-entry slots, so the AXI-Lite side never needs combinational access to the memory port.

---
 rtl/vga_mem_arb_pkg.sv | 19 +
 rtl/vga_mem_arb_host_slot.sv | 43 ++++
 rtl/vga_mem_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_vga_mem_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_mem_arb_pkg.sv
// Shared types for the VGA memory arbiter: grant encoding, statistics width
// and a saturating-increment helper used by the optional statistics counters.
package vga_mem_arb_pkg;

    typedef enum logic [1:0] {
        GNT_NONE    = 2'd0,
        GNT_DISP    = 2'd1,
        GNT_HOST_WR = 2'd2,
        GNT_HOST_RD = 2'd3
    } arb_gnt_e;

    localparam int STAT_WIDTH = 16;

    // Counters stick at all-ones instead of wrapping back to zero
    function automatic logic [STAT_WIDTH-1:0] stat_sat_inc(input logic [STAT_WIDTH-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/vga_mem_arb_host_slot.sv
// One-entry valid/ready holding register for a host request. The payload is
// the address, plus the write data for the write slot. The slot frees on the
// cycle it is granted; ready only rises on the following cycle, so a new
// request is never accepted into a slot that is being drained.
module vga_mem_arb_host_slot
    import vga_mem_arb_pkg::*;
#(
    parameter int PAYLOAD_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [PAYLOAD_WIDTH-1:0] payload_i,
    input  logic                     grant_i,
    output logic                     full_o,
    output logic [PAYLOAD_WIDTH-1:0] payload_o
);

    logic                     full_q;
    logic [PAYLOAD_WIDTH-1:0] payload_q;
    logic                     capture;

    assign ready_o = !full_q && !rst_i;
    assign capture = valid_i && ready_o;

    // Fill on handshake, empty when the arbiter takes the request
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q    <= 1'b0;
            payload_q <= '0;
        end else if (capture) begin
            full_q    <= 1'b1;
            payload_q <= payload_i;
        end else if (grant_i) begin
            full_q    <= 1'b0;
        end
    end

    assign full_o    = full_q;
    assign payload_o = payload_q;

endmodule

// File: rtl/vga_mem_arbiter.sv
// Single-port RAM arbiter between the host (AXI-Lite native side) and the VGA
// display fetch engine. Display wins by default; a starvation counter forces a
// host grant after MAX_DISP_RUN consecutive display grants while host waits.
// Host requests sit in one-entry slots; an age bit keeps host read/write order.
// Optional: define VGA_MEM_ARB_STATS_EN to add host-wait and starve-hit counters.
module vga_mem_arbiter
    import vga_mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_DISP_RUN = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  host_wr_valid_i,
    output logic                  host_wr_ready_o,
    input  logic [ADDR_WIDTH-1:0] host_wr_addr_i,
    input  logic [DATA_WIDTH-1:0] host_wr_data_i,
    input  logic                  host_rd_valid_i,
    output logic                  host_rd_ready_o,
    input  logic [ADDR_WIDTH-1:0] host_rd_addr_i,
    output logic                  host_rvalid_o,
    output logic [DATA_WIDTH-1:0] host_rdata_o,
    input  logic                  disp_req_i,
    input  logic [ADDR_WIDTH-1:0] disp_addr_i,
    output logic                  disp_gnt_o,
    output logic                  disp_rvalid_o,
    output logic [DATA_WIDTH-1:0] disp_rdata_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
`ifdef VGA_MEM_ARB_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] stat_host_wait_o,
    output logic [STAT_WIDTH-1:0] stat_starve_hit_o
`endif
);

    localparam int          WR_PAYLOAD_WIDTH = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [3:0]  MAX_RUN          = 4'(MAX_DISP_RUN);

    logic                        wr_full;
    logic                        rd_full;
    logic [WR_PAYLOAD_WIDTH-1:0] wr_payload;
    logic [ADDR_WIDTH-1:0]       wr_addr_q;
    logic [DATA_WIDTH-1:0]       wr_data_q;
    logic [ADDR_WIDTH-1:0]       rd_addr_q;
    logic                        wr_capture;
    logic                        rd_capture;
    logic                        wr_older_q;
    logic [3:0]                  starve_cnt;
    logic                        host_pend;
    logic                        host_gnt;
    logic                        forced;
    arb_gnt_e                    host_oldest;
    arb_gnt_e                    gnt;
    arb_gnt_e                    rtag_q;

    vga_mem_arb_host_slot #(
        .PAYLOAD_WIDTH(WR_PAYLOAD_WIDTH)
    ) u_wr_slot (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (host_wr_valid_i),
        .ready_o  (host_wr_ready_o),
        .payload_i({host_wr_addr_i, host_wr_data_i}),
        .grant_i  (gnt == GNT_HOST_WR),
        .full_o   (wr_full),
        .payload_o(wr_payload)
    );

    vga_mem_arb_host_slot #(
        .PAYLOAD_WIDTH(ADDR_WIDTH)
    ) u_rd_slot (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (host_rd_valid_i),
        .ready_o  (host_rd_ready_o),
        .payload_i(host_rd_addr_i),
        .grant_i  (gnt == GNT_HOST_RD),
        .full_o   (rd_full),
        .payload_o(rd_addr_q)
    );

    assign {wr_addr_q, wr_data_q} = wr_payload;
    assign wr_capture = host_wr_valid_i && host_wr_ready_o;
    assign rd_capture = host_rd_valid_i && host_rd_ready_o;
    assign host_pend  = wr_full || rd_full;
    assign forced     = host_pend && (starve_cnt == MAX_RUN);
    assign host_gnt   = (gnt == GNT_HOST_WR) || (gnt == GNT_HOST_RD);

    // Pick whichever host slot has been waiting longest
    always_comb begin
        host_oldest = GNT_HOST_RD;
        if (wr_full && (!rd_full || wr_older_q)) begin
            host_oldest = GNT_HOST_WR;
        end
    end

    // One grant per cycle: starvation guard, then display, then host
    always_comb begin
        gnt = GNT_NONE;
        if (!rst_i) begin
            if (forced) begin
                gnt = host_oldest;
            end else if (disp_req_i) begin
                gnt = GNT_DISP;
            end else if (host_pend) begin
                gnt = host_oldest;
            end
        end
    end

    // Age bit: write counts as older on a tie or when the read slot is empty
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_older_q <= 1'b1;
        end else if (wr_capture && rd_capture) begin
            wr_older_q <= 1'b1;
        end else if (wr_capture) begin
            wr_older_q <= !(rd_full && (gnt != GNT_HOST_RD));
        end else if (rd_capture) begin
            wr_older_q <= wr_full && (gnt != GNT_HOST_WR);
        end
    end

    // Count display grants that overtake a waiting host request
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt <= 4'd0;
        end else if (host_gnt || !host_pend) begin
            starve_cnt <= 4'd0;
        end else if ((gnt == GNT_DISP) && (starve_cnt != MAX_RUN)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Remember who owns the read data coming back next cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rtag_q <= GNT_NONE;
        end else if ((gnt == GNT_DISP) || (gnt == GNT_HOST_RD)) begin
            rtag_q <= gnt;
        end else begin
            rtag_q <= GNT_NONE;
        end
    end

    assign host_rvalid_o = !rst_i && (rtag_q == GNT_HOST_RD);
    assign disp_rvalid_o = !rst_i && (rtag_q == GNT_DISP);
    assign host_rdata_o  = mem_rdata_i;
    assign disp_rdata_o  = mem_rdata_i;
    assign disp_gnt_o    = (gnt == GNT_DISP);

    // Drive the RAM port straight from the winning requester
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (gnt)
            GNT_DISP: begin
                mem_en_o   = 1'b1;
                mem_addr_o = disp_addr_i;
            end
            GNT_HOST_WR: begin
                mem_en_o    = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = wr_addr_q;
                mem_wdata_o = wr_data_q;
            end
            GNT_HOST_RD: begin
                mem_en_o   = 1'b1;
                mem_addr_o = rd_addr_q;
            end
            default: begin
                mem_en_o = 1'b0;
            end
        endcase
    end

`ifdef VGA_MEM_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] stat_wait_q;
    logic [STAT_WIDTH-1:0] stat_hit_q;

    // Saturating counts of host wait cycles and forced host grants
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_wait_q <= '0;
            stat_hit_q  <= '0;
        end else begin
            if (host_pend && !host_gnt) begin
                stat_wait_q <= stat_sat_inc(stat_wait_q);
            end
            if (forced) begin
                stat_hit_q <= stat_sat_inc(stat_hit_q);
            end
        end
    end

    assign stat_host_wait_o  = stat_wait_q;
    assign stat_starve_hit_o = stat_hit_q;
`endif

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Self-checking bench for vga_mem_arbiter: a directed vector table, hand-written
// multi-cycle sequences, and a randomized phase. A request-queue reference model
// checks every cycle. Define VGA_MEM_ARB_STATS_EN to also cover the stat ports.
module tb_vga_mem_arbiter;

    localparam int AW      = 16;
    localparam int DW      = 32;
    localparam int MAX_RUN = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          host_wr_valid = 1'b0;
    logic          host_wr_ready;
    logic [AW-1:0] host_wr_addr = '0;
    logic [DW-1:0] host_wr_data = '0;
    logic          host_rd_valid = 1'b0;
    logic          host_rd_ready;
    logic [AW-1:0] host_rd_addr = '0;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          disp_gnt;
    logic          disp_rvalid;
    logic [DW-1:0] disp_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
`ifdef VGA_MEM_ARB_STATS_EN
    logic [15:0]   stat_host_wait;
    logic [15:0]   stat_starve_hit;
`endif

    int checks   = 0;
    int failures = 0;

    vga_mem_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .MAX_DISP_RUN(MAX_RUN)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .host_wr_valid_i(host_wr_valid),
        .host_wr_ready_o(host_wr_ready),
        .host_wr_addr_i (host_wr_addr),
        .host_wr_data_i (host_wr_data),
        .host_rd_valid_i(host_rd_valid),
        .host_rd_ready_o(host_rd_ready),
        .host_rd_addr_i (host_rd_addr),
        .host_rvalid_o  (host_rvalid),
        .host_rdata_o   (host_rdata),
        .disp_req_i     (disp_req),
        .disp_addr_i    (disp_addr),
        .disp_gnt_o     (disp_gnt),
        .disp_rvalid_o  (disp_rvalid),
        .disp_rdata_o   (disp_rdata),
        .mem_en_o       (mem_en),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata)
`ifdef VGA_MEM_ARB_STATS_EN
        ,
        .stat_host_wait_o (stat_host_wait),
        .stat_starve_hit_o(stat_starve_hit)
`endif
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Synchronous-read RAM attached to the arbiter's memory port
    logic [DW-1:0] ram [0:65535] = '{default: 32'h0};
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checkOutput(name, 32'(actual), 32'(expected));
    endtask

    // Drive one cycle of inputs just after the rising edge, return at the falling edge
    task automatic applyStimulus(input logic r, input logic wv, input logic [AW-1:0] wa,
                                 input logic [DW-1:0] wd, input logic rv, input logic [AW-1:0] ra,
                                 input logic dq, input logic [AW-1:0] da);
        @(posedge clk);
        #1;
        rst           = r;
        host_wr_valid = wv;
        host_wr_addr  = wa;
        host_wr_data  = wd;
        host_rd_valid = rv;
        host_rd_addr  = ra;
        disp_req      = dq;
        disp_addr     = da;
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    // Idle until a host read returns (bounded) and check its data
    task automatic waitHostRead(input string name, input logic [31:0] expected);
        bit seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            idleCycle();
            if (host_rvalid) begin
                seen = 1'b1;
                checkOutput(name, host_rdata, expected);
            end
        end
        checkBit({name, "_seen"}, seen, 1'b1);
    endtask

    // ------------------------------------------------------------------
    // Reference model: host requests as an ordered queue (oldest first),
    // a run length of display grants overtaking waiting host work, and a
    // shadow copy of memory for expected read data.
    // ------------------------------------------------------------------
    typedef struct {
        bit            is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    req_t          mq[$];
    logic [DW-1:0] shadow [int];
    int            m_run      = 0;
    int            m_ret      = 0;
    logic [DW-1:0] m_ret_data = '0;
    int            m_wait     = 0;
    int            m_hit      = 0;

    function automatic logic [DW-1:0] shadowRead(input logic [AW-1:0] a);
        return shadow.exists(int'(a)) ? shadow[int'(a)] : '0;
    endfunction

    // Predict this cycle's outputs from the model, compare, then advance the model
    always @(negedge clk) begin : model
        bit            wfull;
        bit            rfull;
        bit            pend;
        bit            forced;
        bit            wcap;
        bit            rcap;
        int            g;
        logic [AW-1:0] gaddr;
        req_t          nr;
        if (rst) begin
            checkBit("mdl_rst_mem_en", mem_en, 1'b0);
            checkBit("mdl_rst_disp_gnt", disp_gnt, 1'b0);
            checkBit("mdl_rst_wr_ready", host_wr_ready, 1'b0);
            checkBit("mdl_rst_rd_ready", host_rd_ready, 1'b0);
            checkBit("mdl_rst_host_rvalid", host_rvalid, 1'b0);
            checkBit("mdl_rst_disp_rvalid", disp_rvalid, 1'b0);
            mq.delete();
            m_run  = 0;
            m_ret  = 0;
            m_wait = 0;
            m_hit  = 0;
        end else begin
            wfull = 1'b0;
            rfull = 1'b0;
            foreach (mq[i]) begin
                if (mq[i].is_wr) wfull = 1'b1;
                else             rfull = 1'b1;
            end
            pend   = (mq.size() != 0);
            forced = pend && (m_run == MAX_RUN);
            if (forced)        g = mq[0].is_wr ? 2 : 3;
            else if (disp_req) g = 1;
            else if (pend)     g = mq[0].is_wr ? 2 : 3;
            else               g = 0;

            checkBit("mdl_wr_ready", host_wr_ready, !wfull);
            checkBit("mdl_rd_ready", host_rd_ready, !rfull);
            checkBit("mdl_host_rvalid", host_rvalid, m_ret == 2);
            checkBit("mdl_disp_rvalid", disp_rvalid, m_ret == 1);
            if (m_ret == 2) checkOutput("mdl_host_rdata", host_rdata, m_ret_data);
            if (m_ret == 1) checkOutput("mdl_disp_rdata", disp_rdata, m_ret_data);
            checkBit("mdl_mem_en", mem_en, g != 0);
            checkBit("mdl_mem_we", mem_we, g == 2);
            checkBit("mdl_disp_gnt", disp_gnt, g == 1);
            if (g == 1)      gaddr = disp_addr;
            else if (g != 0) gaddr = mq[0].addr;
            else             gaddr = '0;
            if (g != 0) checkOutput("mdl_mem_addr", 32'(mem_addr), 32'(gaddr));
            if (g == 2) checkOutput("mdl_mem_wdata", mem_wdata, mq[0].data);
`ifdef VGA_MEM_ARB_STATS_EN
            checkOutput("mdl_stat_host_wait", 32'(stat_host_wait), 32'(m_wait));
            checkOutput("mdl_stat_starve_hit", 32'(stat_starve_hit), 32'(m_hit));
`endif
            if (pend && g != 2 && g != 3 && m_wait < 65535) m_wait++;
            if (forced && m_hit < 65535) m_hit++;

            wcap = host_wr_valid && !wfull;
            rcap = host_rd_valid && !rfull;
            if (g == 2 || g == 3 || !pend)   m_run = 0;
            else if (g == 1 && m_run < MAX_RUN) m_run++;

            m_ret = 0;
            if (g == 1) begin
                m_ret      = 1;
                m_ret_data = shadowRead(disp_addr);
            end else if (g == 3) begin
                m_ret      = 2;
                m_ret_data = shadowRead(mq[0].addr);
            end else if (g == 2) begin
                shadow[int'(mq[0].addr)] = mq[0].data;
            end
            if (g == 2 || g == 3) void'(mq.pop_front());
            if (wcap) begin
                nr.is_wr = 1'b1;
                nr.addr  = host_wr_addr;
                nr.data  = host_wr_data;
                mq.push_back(nr);
            end
            if (rcap) begin
                nr.is_wr = 1'b0;
                nr.addr  = host_rd_addr;
                nr.data  = '0;
                mq.push_back(nr);
            end
        end
    end

    // Hang guard
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic          wv;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          rv;
        logic [AW-1:0] ra;
        logic          dq;
        logic [AW-1:0] da;
        logic          en;
        logic          we;
        logic [AW-1:0] addr;
        logic          gnt;
        logic          wrdy;
        logic          rrdy;
        logic          hrv;
        logic          drv;
        logic [DW-1:0] rdata;
    } vec_t;

    vec_t tbl [10];

    // Main stimulus sequence
    initial begin : stimulus
        int ndisp;
        int host_at;
        logic dq_r;

        //            wv    wa        wd            rv    ra        dq    da        en    we    addr      gnt   wrdy  rrdy  hrv   drv   rdata
        tbl[0] = '{1'b1, 16'h0010, 32'hDEADBEEF, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 16'h0000, 32'h0,        1'b1, 16'h0010, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[2] = '{1'b0, 16'h0000, 32'h0,        1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[3] = '{1'b0, 16'h0000, 32'h0,        1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF};
        tbl[4] = '{1'b0, 16'h0000, 32'h0,        1'b0, 16'h0000, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[5] = '{1'b0, 16'h0000, 32'h0,        1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
        tbl[6] = '{1'b1, 16'h0030, 32'h7,        1'b0, 16'h0000, 1'b1, 16'h0005, 1'b1, 1'b0, 16'h0005, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[7] = '{1'b0, 16'h0000, 32'h0,        1'b0, 16'h0000, 1'b1, 16'h0006, 1'b1, 1'b0, 16'h0006, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0};
        tbl[8] = '{1'b0, 16'h0000, 32'h0,        1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0030, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0};
        tbl[9] = '{1'b0, 16'h0000, 32'h0,        1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};

        // Reset: nothing ready, no memory traffic
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1, 16'h0001);
        checkBit("reset_wr_ready", host_wr_ready, 1'b0);
        checkBit("reset_rd_ready", host_rd_ready, 1'b0);
        checkBit("reset_mem_en", mem_en, 1'b0);
        checkBit("reset_disp_gnt", disp_gnt, 1'b0);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].rv, tbl[i].ra, tbl[i].dq, tbl[i].da);
            checkBit($sformatf("tbl%0d_mem_en", i), mem_en, tbl[i].en);
            checkBit($sformatf("tbl%0d_mem_we", i), mem_we, tbl[i].we);
            checkBit($sformatf("tbl%0d_disp_gnt", i), disp_gnt, tbl[i].gnt);
            checkBit($sformatf("tbl%0d_wr_ready", i), host_wr_ready, tbl[i].wrdy);
            checkBit($sformatf("tbl%0d_rd_ready", i), host_rd_ready, tbl[i].rrdy);
            checkBit($sformatf("tbl%0d_host_rvalid", i), host_rvalid, tbl[i].hrv);
            checkBit($sformatf("tbl%0d_disp_rvalid", i), disp_rvalid, tbl[i].drv);
            if (tbl[i].en)  checkOutput($sformatf("tbl%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].addr));
            if (tbl[i].hrv) checkOutput($sformatf("tbl%0d_host_rdata", i), host_rdata, tbl[i].rdata);
            if (tbl[i].drv) checkOutput($sformatf("tbl%0d_disp_rdata", i), disp_rdata, tbl[i].rdata);
        end

        // Starvation guard: display held high while a write waits
        applyStimulus(1'b0, 1'b1, 16'h0050, 32'h55, 1'b0, '0, 1'b1, 16'h0001);
        ndisp   = 0;
        host_at = -1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 16'(i + 2));
            if (host_at < 0) begin
                if (mem_we) begin
                    host_at = i;
                    checkOutput("starve_host_addr", 32'(mem_addr), 32'h0050);
                end else if (disp_gnt) begin
                    ndisp++;
                end
            end else if (i == host_at + 1) begin
                checkBit("starve_disp_resumes", disp_gnt, 1'b1);
                checkOutput("starve_cnt_cleared", 32'(dut.starve_cnt), 32'd0);
            end
        end
        checkOutput("starve_disp_run", 32'(ndisp), 32'(MAX_RUN));
        checkOutput("starve_host_cycle", 32'(host_at), 32'(MAX_RUN));
        idleCycle();
        idleCycle();

        // Write and read accepted together: write goes first, read sees new data
        applyStimulus(1'b0, 1'b1, 16'h0020, 32'h1, 1'b0, '0, 1'b0, '0);
        idleCycle();
        idleCycle();
        applyStimulus(1'b0, 1'b1, 16'h0020, 32'h2, 1'b1, 16'h0020, 1'b0, '0);
        idleCycle();
        checkBit("simul_write_first", mem_we, 1'b1);
        checkOutput("simul_write_addr", 32'(mem_addr), 32'h0020);
        waitHostRead("simul_read_new", 32'h2);

        // Read accepted one cycle before a write to the same address sees old data
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 16'h0020, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 16'h0020, 32'h3, 1'b0, '0, 1'b0, '0);
        waitHostRead("rd_before_wr_old", 32'h2);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 16'h0020, 1'b0, '0);
        waitHostRead("rd_after_wr_new", 32'h3);

        // Reset while the write slot is full and a display read is in flight
        applyStimulus(1'b0, 1'b1, 16'h0040, 32'h9, 1'b0, '0, 1'b1, 16'h0010);
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
        checkBit("rst_mid_mem_en", mem_en, 1'b0);
        checkBit("rst_mid_disp_rvalid", disp_rvalid, 1'b0);
        idleCycle();
        checkBit("rst_after_mem_en", mem_en, 1'b0);
        checkBit("rst_after_disp_rvalid", disp_rvalid, 1'b0);
        checkBit("rst_after_host_rvalid", host_rvalid, 1'b0);
        checkBit("rst_after_wr_ready", host_wr_ready, 1'b1);
        checkBit("rst_after_rd_ready", host_rd_ready, 1'b1);
        idleCycle();
        checkBit("rst_after2_mem_en", mem_en, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 16'h0040, 1'b0, '0);
        waitHostRead("rst_dropped_write", 32'h0);

        // Randomized traffic against the reference model
        dq_r = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) dq_r = !dq_r;
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 2) == 0, 16'($urandom_range(0, 15)), $urandom,
                          $urandom_range(0, 2) == 0, 16'($urandom_range(0, 15)),
                          dq_r, 16'($urandom_range(0, 15)));
        end
        for (int i = 0; i < 4; i++) idleCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
